control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Multi-cycle FSM that drives the load enables (en) of the CPU's 16-bit datapath registers: PC, IR, MDR, ACC.
//  Decodes IR[15:12] and sequences fetch, decode, memory access and execute.
//  Handshakes with memory via rd/wr strobes and mem_ready.
//  Each enable is asserted for exactly the one cycle in which the target register must capture.
// PARAMETERS
//  OPW      4   opcode width, IR[15:16-OPW]
//  TIMEOUT  15  max cycles waiting for mem_ready before fault (>=1)
//  TW       4   timeout counter width, must hold TIMEOUT
// PORTS
//  clk        in   1  single clock; all state updates on posedge
//  rst        in   1  asynchronous, active-low reset
//  ir_op      in   4  opcode from the IR register output
//  acc_zero   in   1  ACC==0 flag from the datapath
//  mem_ready  in   1  memory completes the current rd/wr this cycle
//  pc_en      out  1  PC load enable
//  pc_sel     out  1  0: PC+1, 1: IR[11:0] (jump target)
//  ir_en      out  1  IR load enable
//  mdr_en     out  1  MDR load enable
//  acc_en     out  1  ACC load enable
//  alu_op     out  2  00 PASS(MDR), 01 ADD, 10 SUB, 11 reserved
//  addr_sel   out  1  0: memory address from PC, 1: from IR[11:0]
//  mem_rd     out  1  memory read strobe, held until mem_ready
//  mem_wr     out  1  memory write strobe (ACC to memory), held until mem_ready
//  halted     out  1  CPU stopped (HALT instruction or fault)
//  fault      out  1  illegal opcode or memory timeout
// BEHAVIOUR
//  Reset (rst=0, async): state=FETCH, timer=0; all outputs 0; halted=0, fault=0.
//  Outputs are combinational decode of state, ir_op, acc_zero and mem_ready; state, timer and fault are registered.
//  Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 JMP, 6 JZ, F HALT; all others illegal.
//  FETCH:  mem_rd=1, addr_sel=0.
//          On mem_ready: ir_en=1, pc_en=1, pc_sel=0 in the same cycle, then go to DECODE.
//  DECODE: exactly one cycle, no memory strobes.
//          NOP -> FETCH.
//          JMP: pc_en=1, pc_sel=1 -> FETCH.
//          JZ: pc_en=acc_zero, pc_sel=1 -> FETCH.
//          LOAD/ADD/SUB -> MEM_RD.  STORE -> MEM_WR.  HALT -> HALT.
//          Illegal opcode: fault<=1 -> HALT.
//  MEM_RD: mem_rd=1, addr_sel=1.
//          On mem_ready: mdr_en=1, then go to EXEC.
//  EXEC:   acc_en=1; alu_op = PASS for LOAD, ADD for ADD, SUB for SUB; then -> FETCH.
//  MEM_WR: mem_wr=1, addr_sel=1.
//          On mem_ready -> FETCH.  mem_ready on the first cycle is legal (zero wait).
//  HALT:   halted=1, all enables and strobes 0; stays until reset.
//  Timer:  cleared on every state change.
//          Increments each cycle spent in FETCH/MEM_RD/MEM_WR without mem_ready.
//          Timer reaching TIMEOUT with no mem_ready: fault<=1 -> HALT.
//          mem_ready in the same cycle the timer hits TIMEOUT: the transfer wins, no fault.
//  mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
//  mem_rd and mem_wr are never both 1.  At most one of ir_en/mdr_en/acc_en is 1 per cycle.
//  Latency (zero-wait memory): NOP/JMP/JZ 2 cycles, STORE 3, LOAD/ADD/SUB 4.
//  Reset mid-operation: strobes drop immediately (async); resumes at FETCH.
// STRUCTURE
//  cpu_pkg: opcode localparams, state encoding (FETCH, DECODE, MEM_RD, EXEC, MEM_WR, HALT), ALU_PASS/ADD/SUB, PC_INC/PC_JMP.
//  Sub-module cu_wait_timer: TW-bit counter with clear/inc and a timeout flag.
//  Single two-process FSM otherwise.
// TESTING
//  Reset then LOAD, ir_op=1, zero-wait mem -> ir_en,pc_en @c0; MEM_RD; mdr_en @c2; acc_en, alu_op=00 @c3; FETCH @c4.
//  JZ, ir_op=6: acc_zero=1 -> pc_en=1, pc_sel=1 in DECODE; acc_zero=0 -> pc_en=0; both return to FETCH.
//  STORE with mem_ready delayed 3 cycles -> mem_wr=1, addr_sel=1 held 4 cycles, no other enables, then FETCH.
//  FETCH with mem_ready never asserted, TIMEOUT=15 -> fault=1, halted=1 after 16 cycles in FETCH; rst=0 clears both.
//  ir_op=9 (illegal) -> DECODE sets fault, then HALT; ir_op=F -> halted=1, fault=0, no strobes for 20 cycles.
//  Assert rst=0 mid-MEM_RD -> mem_rd drops before the next clk edge; after release, first cycle is FETCH with mem_rd=1, addr_sel=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle CPU control unit: opcodes, FSM state
// encoding, ALU operation codes and PC source select values.
package cpu_pkg;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_JZ    = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_MEM_RD = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM_WR = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  localparam logic PC_INC = 1'b0;
  localparam logic PC_JMP = 1'b1;
endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath/memory signal bundle. master = control unit side,
// slave = datapath/memory side.
interface control_unit_if #(parameter int OPW = 4);
  logic [OPW-1:0] ir_op;
  logic           acc_zero;
  logic           mem_ready;
  logic           pc_en;
  logic           pc_sel;
  logic           ir_en;
  logic           mdr_en;
  logic           acc_en;
  logic [1:0]     alu_op;
  logic           addr_sel;
  logic           mem_rd;
  logic           mem_wr;
  logic           halted;
  logic           fault;

  modport master (
    input  ir_op, acc_zero, mem_ready,
    output pc_en, pc_sel, ir_en, mdr_en, acc_en, alu_op, addr_sel,
           mem_rd, mem_wr, halted, fault
  );

  modport slave (
    output ir_op, acc_zero, mem_ready,
    input  pc_en, pc_sel, ir_en, mdr_en, acc_en, alu_op, addr_sel,
           mem_rd, mem_wr, halted, fault
  );
endinterface

// File: rtl/cu_wait_timer.sv
// Counts cycles spent waiting on mem_ready; flags when the count has reached
// TIMEOUT. Clear has priority over increment.
module cu_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic timeout
);
  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == TW'(TIMEOUT));
endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch/decode/memory/execute sequencing with one-cycle
// register load enables, memory handshake and timeout/illegal-opcode fault.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master bus
);
  logic [2:0]     state_q, state_d;
  logic           fault_q, fault_d;
  logic [OPW-1:0] op;
  logic           ready, tmo, waiting;
  logic           tmr_clr, tmr_inc;
  logic           pc_en, pc_sel, ir_en, mdr_en, acc_en, addr_sel, mem_rd, mem_wr;
  logic [1:0]     alu_op;

  assign op    = bus.ir_op;
  assign ready = bus.mem_ready;

  always_comb begin
    state_d  = state_q;
    fault_d  = fault_q;
    pc_en    = 1'b0;
    pc_sel   = PC_INC;
    ir_en    = 1'b0;
    mdr_en   = 1'b0;
    acc_en   = 1'b0;
    alu_op   = ALU_PASS;
    addr_sel = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    waiting  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd  = 1'b1;
        waiting = 1'b1;
        if (ready) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        case (op)
          OP_NOP:  state_d = S_FETCH;
          OP_JMP: begin
            pc_en   = 1'b1;
            pc_sel  = PC_JMP;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            pc_en   = bus.acc_zero;
            pc_sel  = PC_JMP;
            state_d = S_FETCH;
          end
          OP_LOAD, OP_ADD, OP_SUB: state_d = S_MEM_RD;
          OP_STORE: state_d = S_MEM_WR;
          OP_HALT:  state_d = S_HALT;
          default: begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_MEM_RD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        waiting  = 1'b1;
        if (ready) begin
          mdr_en  = 1'b1;
          state_d = S_EXEC;
        end else if (tmo) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        acc_en = 1'b1;
        case (op)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          default: alu_op = ALU_PASS;
        endcase
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
        waiting  = 1'b1;
        if (ready) begin
          state_d = S_FETCH;
        end else if (tmo) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign tmr_clr = (state_d != state_q);
  assign tmr_inc = waiting & ~ready;

  cu_wait_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .timeout (tmo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Gate with rst so strobes drop the moment reset asserts, not at the next edge.
  assign bus.pc_en    = rst & pc_en;
  assign bus.pc_sel   = rst & pc_sel;
  assign bus.ir_en    = rst & ir_en;
  assign bus.mdr_en   = rst & mdr_en;
  assign bus.acc_en   = rst & acc_en;
  assign bus.alu_op   = rst ? alu_op : ALU_PASS;
  assign bus.addr_sel = rst & addr_sel;
  assign bus.mem_rd   = rst & mem_rd;
  assign bus.mem_wr   = rst & mem_wr;
  assign bus.halted   = rst & (state_q == S_HALT);
  assign bus.fault    = rst & fault_q;
endmodule

// File: tb/tb_control_unit.sv
// Randomized instruction stream checked cycle-by-cycle against a transaction-level
// model that expands each instruction into its expected output sequence.
module tb_control_unit;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_unit_if #(.OPW(4)) bus ();
  control_unit #(.OPW(4), .TIMEOUT(TIMEOUT), .TW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {pc_en,pc_sel,ir_en,mdr_en,acc_en,alu_op,addr_sel,mem_rd,mem_wr,halted,fault}
  function automatic logic [11:0] obs();
    return {bus.pc_en, bus.pc_sel, bus.ir_en, bus.mdr_en, bus.acc_en, bus.alu_op,
            bus.addr_sel, bus.mem_rd, bus.mem_wr, bus.halted, bus.fault};
  endfunction

  function automatic logic [11:0] ev(input bit pe, ps, ie, me, ae, input bit [1:0] alu,
                                     input bit as, rd, wr, h, f);
    return {pe, ps, ie, me, ae, alu, as, rd, wr, h, f};
  endfunction

  // Called at posedge+1: drive inputs, check combinational outputs, advance one cycle.
  task automatic step(input string tag, input logic [3:0] op, input bit rdy, input bit az,
                      input logic [11:0] exp);
    bus.ir_op     = op;
    bus.mem_ready = rdy;
    bus.acc_zero  = az;
    #1 chk(tag, 32'(obs()), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1 chk("rst_outs", 32'(obs()), 32'd0);
    @(posedge clk);
    #1 chk("rst_hold", 32'(obs()), 32'd0);
    rst = 1'b1;
  endtask

  task automatic halt_cycles(input int n, input bit f);
    for (int i = 0; i < n; i++)
      step("halt", 4'($urandom), 1'($urandom), 1'($urandom), ev(0,0,0,0,0,0,0,0,0,1,f));
  endtask

  // Memory phase: wait cycles (strobe held), then the ready cycle, or a timeout.
  // Returns 1 if the wait timed out.
  task automatic mem_phase(input string tag, input logic [3:0] op, input int w,
                           input bit is_wr, output bit timed_out);
    logic [11:0] held;
    held = ev(0,0,0,0,0,0,1,!is_wr,is_wr,0,0);
    timed_out = 1'b0;
    for (int i = 0; i < w && i <= TIMEOUT; i++)
      step({tag, "_wait"}, op, 1'b0, 1'($urandom), held);
    if (w > TIMEOUT) begin
      timed_out = 1'b1;
      return;
    end
    step({tag, "_done"}, op, 1'b1, 1'($urandom), held | ev(0,0,0,!is_wr,0,0,0,0,0,0,0));
  endtask

  // Expand one instruction into expected cycles. fw/mw = cycles before mem_ready.
  // Returns 1 if the CPU ended up halted (then already checked in HALT).
  task automatic do_instr(input logic [3:0] op, input int fw, input int mw, output bit stopped);
    bit az, to;
    bit [1:0] alu;
    stopped = 1'b0;
    for (int i = 0; i < fw && i <= TIMEOUT; i++)
      step("fetch_wait", 4'($urandom), 1'b0, 1'($urandom), ev(0,0,0,0,0,0,0,1,0,0,0));
    if (fw > TIMEOUT) begin
      halt_cycles(3, 1'b1);
      stopped = 1'b1;
      return;
    end
    step("fetch_done", 4'($urandom), 1'b1, 1'($urandom), ev(1,0,1,0,0,0,0,1,0,0,0));
    az = 1'($urandom);
    case (op)
      4'h5: step("dec_jmp", op, 1'($urandom), az, ev(1,1,0,0,0,0,0,0,0,0,0));
      4'h6: step("dec_jz", op, 1'($urandom), az, ev(az,1,0,0,0,0,0,0,0,0,0));
      default: step("decode", op, 1'($urandom), az, 12'd0);
    endcase
    case (op)
      4'h0, 4'h5, 4'h6: ;
      4'h1, 4'h3, 4'h4: begin
        mem_phase("rd", op, mw, 1'b0, to);
        if (to) begin
          halt_cycles(3, 1'b1);
          stopped = 1'b1;
        end else begin
          alu = (op == 4'h3) ? 2'b01 : (op == 4'h4) ? 2'b10 : 2'b00;
          step("exec", op, 1'($urandom), 1'($urandom), ev(0,0,0,0,1,alu,0,0,0,0,0));
        end
      end
      4'h2: begin
        mem_phase("wr", op, mw, 1'b1, to);
        if (to) begin
          halt_cycles(3, 1'b1);
          stopped = 1'b1;
        end
      end
      4'hF: begin
        halt_cycles(20, 1'b0);
        stopped = 1'b1;
      end
      default: begin
        halt_cycles(3, 1'b1);
        stopped = 1'b1;
      end
    endcase
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return int'($urandom_range(14, 16));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    bit st;
    logic [3:0] op;
    int r;
    bus.ir_op = 4'h0; bus.mem_ready = 1'b0; bus.acc_zero = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Directed: latency/handshake cases, then timeout boundaries.
    do_instr(4'h1, 0, 0, st);   // LOAD zero-wait
    bus.acc_zero = 1'b1;
    do_instr(4'h6, 0, 0, st);   // JZ
    do_instr(4'h2, 0, 3, st);   // STORE, ready after 3 waits
    do_instr(4'h3, 2, 15, st);  // ADD: ready exactly at timeout wins
    do_instr(4'h4, 0, 1, st);
    do_instr(4'h2, 0, 0, st);   // STORE zero-wait
    do_instr(4'h0, 15, 0, st);  // fetch ready at timeout wins
    do_instr(4'h0, 16, 0, st);  // fetch never ready -> fault
    do_reset();
    do_instr(4'h9, 0, 0, st);   // illegal
    do_reset();
    do_instr(4'hF, 1, 0, st);   // HALT
    do_reset();

    // Reset asserted while waiting in MEM_RD.
    step("fetch_done", 4'h0, 1'b1, 1'b0, ev(1,0,1,0,0,0,0,1,0,0,0));
    step("decode", 4'h1, 1'b0, 1'b0, 12'd0);
    step("rd_wait", 4'h1, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,1,0,0,0));
    bus.mem_ready = 1'b0;
    #1 chk("rd_wait2", 32'(obs()), 32'(ev(0,0,0,0,0,0,1,1,0,0,0)));
    rst = 1'b0;
    #1 chk("rst_mid_rd", 32'(bus.mem_rd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("post_rst_fetch", 32'(obs()), 32'(ev(0,0,0,0,0,0,0,1,0,0,0)));
    @(posedge clk); #1;
    step("fetch_wait", 4'h0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,1,0,0,0));

    // Resynchronise: fetch has two wait cycles behind it, timer still counting.
    do_instr(4'h0, 0, 0, st);

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 16)       op = 4'(r % 7);
      else if (r < 18)  op = 4'($urandom_range(7, 14));
      else if (r == 18) op = 4'hF;
      else              op = 4'(r % 7);
      do_instr(op, pick_wait(), pick_wait(), st);
      if (st) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
